l1_thresh_regs: RTL
===================

L1_THRESH_REGS -- requirements
Module: l1_thresh_regs

Interface
REQ-001 SHALL have parameter NBEAMS, default 48, meaning number of L1 beams.
REQ-002 SHALL have parameter THRESH_BITS, default 18, meaning threshold width.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 65535, meaning cycles to wait for thr_done_i.
REQ-004 SHALL have one clock and a synchronous, active-high reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  sync active-high reset.
REQ-005 SHALL have Wishbone slave inputs: wb_cyc_i in 1; wb_stb_i in 1; wb_adr_i in 13 (byte address); wb_dat_i in 32; wb_we_i in 1; wb_sel_i in 4 (ignored, full-word only).
REQ-006 SHALL have Wishbone slave outputs: wb_ack_o out 1; wb_err_o out 1 (tied 0); wb_rty_o out 1 (tied 0); wb_dat_o out 32.
REQ-007 SHALL have downstream outputs: thr_dat_o out THRESH_BITS; thr_addr_o out 7 ({sub, beam[5:0]}); thr_valid_o out 1; thr_commit_o out 1.
REQ-008 SHALL have downstream inputs: thr_ready_i in 1 (beat accept); thr_done_i in 1 (trigger has applied the commit).

Function
REQ-009 SHALL assert wb_ack_o for exactly one cycle, one cycle after cyc&stb is first seen, with no re-ack until cyc&stb deasserts.
REQ-010 SHALL decode word index wb_adr_i[12:2]: 0x000-0x0BC trigger threshold beam n at n*4; 0x200-0x2BC subthreshold beam n; 0x400 CTRL/STAT; 0x404 UPDATE_COUNT; all other addresses read 0, writes discarded, still acked.
REQ-011 SHALL store threshold writes as wb_dat_i[THRESH_BITS-1:0] and read them back zero-extended to 32 bits.
REQ-012 SHALL, on a CTRL write with bit0=1 while IDLE, start an update; bits 1-3 written as 1 SHALL clear the corresponding sticky status bits (W1C).
REQ-013 SHALL read CTRL/STAT as bit0 busy (not IDLE), bit1 drop, bit2 overrun, bit3 timeout, other bits 0.
REQ-014 SHALL implement FSM IDLE -> STREAM -> COMMIT -> WAIT_DONE -> IDLE.
REQ-015 STREAM SHALL present 2*NBEAMS beats in order trigger 0..NBEAMS-1, then subthreshold 0..NBEAMS-1; thr_addr_o bit6 = 1 for subthreshold.
REQ-016 thr_valid_o SHALL hold with thr_dat_o/thr_addr_o stable until a cycle with thr_ready_i=1; the next beat SHALL appear no later than the cycle after acceptance.
REQ-017 First thr_valid_o SHALL assert at most 2 cycles after the update-request ack cycle.
REQ-018 After the last beat is accepted, COMMIT SHALL pulse thr_commit_o for exactly one cycle, then enter WAIT_DONE.
REQ-019 WAIT_DONE SHALL sample thr_done_i from the cycle after commit; on thr_done_i=1 SHALL return to IDLE and increment UPDATE_COUNT (16-bit, wraps 0xFFFF->0x0000).
REQ-020 WAIT_DONE SHALL count cycles; on reaching DONE_TIMEOUT without thr_done_i SHALL set timeout sticky, return to IDLE and not increment UPDATE_COUNT.
REQ-021 An update request while busy SHALL be ignored and set overrun sticky.
REQ-022 Threshold writes while busy SHALL be acked, discarded and set drop sticky; reads while busy SHALL return stored values.
REQ-023 A threshold write and a CTRL update request cannot coincide (single Wishbone port); a W1C and a same-cycle set event SHALL leave the bit set.

Reset
REQ-024 Reset SHALL force IDLE, thr_valid_o=0, thr_commit_o=0, wb_ack_o=0, wb_dat_o=0, sticky bits=0, UPDATE_COUNT=0, timeout counter=0.
REQ-025 Reset SHALL NOT alter threshold storage; reset mid-STREAM SHALL abort with no commit pulse.

Structure
REQ-026 A shared package l1_thresh_pkg SHALL hold the FSM state enum, register offsets (THR_TRIG_BASE, THR_SUB_BASE, CTRL_ADR, COUNT_ADR) and CTRL bit positions.
REQ-027 Threshold storage SHALL be a sub-module l1_thresh_ram: 2*NBEAMS x THRESH_BITS, one Wishbone read/write port, one registered read port for streaming (1-cycle latency).

Verification
REQ-028 Write 0x0001_2345 to 0x008, read 0x008 -> 0x0001_2345 (18-bit masked); read 0x0C0 -> 0, acked.
REQ-029 Write distinct values, CTRL=0x1, thr_ready_i=1 -> 96 beats, addr 0x00..0x2F then 0x40..0x6F with written data, one commit pulse; thr_done_i after 5 cycles -> busy=0, UPDATE_COUNT=1.
REQ-030 thr_ready_i toggled pseudo-randomly -> no beat lost/duplicated, data stable while valid&!ready.
REQ-031 CTRL=0x1 and threshold write during STREAM -> STAT=0x7 (busy, drop, overrun); write CTRL=0x6 after done -> STAT=0x0, stored value unchanged.
REQ-032 thr_done_i never asserted (DONE_TIMEOUT=100) -> IDLE 100 cycles after commit, STAT bit3=1, UPDATE_COUNT unchanged.
REQ-033 wb_rst_i at beat 10 -> thr_valid_o=0 next cycle, no commit, stored thresholds read back unchanged.

Source files
------------

// File: rtl/l1_thresh_pkg.sv
// l1_thresh_pkg : shared FSM state, register map and CTRL bit positions for the L1 threshold block.
// Rev 1.0
`default_nettype none

package l1_thresh_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_STREAM    = 2'd1,
      ST_COMMIT    = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_e;

   localparam logic [12:0] THR_TRIG_BASE = 13'h000;
   localparam logic [12:0] THR_SUB_BASE  = 13'h200;
   localparam logic [12:0] CTRL_ADR      = 13'h400;
   localparam logic [12:0] COUNT_ADR     = 13'h404;

   localparam int CTRL_START_BIT   = 0;
   localparam int CTRL_DROP_BIT    = 1;
   localparam int CTRL_OVERRUN_BIT = 2;
   localparam int CTRL_TIMEOUT_BIT = 3;

   function automatic logic [10:0] word_of(input logic [12:0] adr);
      return adr[12:2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/l1_thresh_ram.sv
// l1_thresh_ram : threshold storage, async-read Wishbone port plus registered streaming read port.
// Rev 1.0
`default_nettype none

module l1_thresh_ram
   import l1_thresh_pkg::*;
#(
   parameter int DEPTH = 96,
   parameter int WIDTH = 18,
   parameter int IDX_W = 7
) (
   input  logic             clk_i,
   input  logic             wb_we_i,
   input  logic [IDX_W-1:0] wb_idx_i,
   input  logic [WIDTH-1:0] wb_dat_i,
   output logic [WIDTH-1:0] wb_dat_o,
   input  logic             strm_en_i,
   input  logic [IDX_W-1:0] strm_idx_i,
   output logic [WIDTH-1:0] strm_dat_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] strm_dat_q;

   // Storage is deliberately not reset so thresholds survive a bus reset.
   always_ff @(posedge clk_i) begin
      if (wb_we_i) begin
         mem_q[wb_idx_i] <= wb_dat_i;
      end
      if (strm_en_i) begin
         strm_dat_q <= mem_q[strm_idx_i];
      end
   end

   assign wb_dat_o   = mem_q[wb_idx_i];
   assign strm_dat_o = strm_dat_q;

endmodule

`default_nettype wire

// File: rtl/l1_thresh_regs.sv
// l1_thresh_regs : Wishbone threshold register file that streams and commits thresholds downstream.
// Rev 1.0
`default_nettype none

module l1_thresh_regs
   import l1_thresh_pkg::*;
#(
   parameter int NBEAMS       = 48,
   parameter int THRESH_BITS  = 18,
   parameter int DONE_TIMEOUT = 65535
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wb_cyc_i,
   input  logic                   wb_stb_i,
   input  logic [12:0]            wb_adr_i,
   input  logic [31:0]            wb_dat_i,
   input  logic                   wb_we_i,
   input  logic [3:0]             wb_sel_i,
   output logic                   wb_ack_o,
   output logic                   wb_err_o,
   output logic                   wb_rty_o,
   output logic [31:0]            wb_dat_o,
   output logic [THRESH_BITS-1:0] thr_dat_o,
   output logic [6:0]             thr_addr_o,
   output logic                   thr_valid_o,
   output logic                   thr_commit_o,
   input  logic                   thr_ready_i,
   input  logic                   thr_done_i
);

   localparam int DEPTH = 2 * NBEAMS;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TO_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;

   localparam logic [10:0]      WRD_TRIG  = THR_TRIG_BASE[12:2];
   localparam logic [10:0]      WRD_SUB   = THR_SUB_BASE[12:2];
   localparam logic [10:0]      WRD_CTRL  = CTRL_ADR[12:2];
   localparam logic [10:0]      WRD_COUNT = COUNT_ADR[12:2];
   localparam logic [10:0]      NB_WRD    = 11'(NBEAMS);
   localparam logic [CNT_W-1:0] BEATS     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] NB_CNT    = CNT_W'(NBEAMS);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(DONE_TIMEOUT - 1);

   logic ack_q, served_q;
   logic [31:0] wb_dat_q;
   logic drop_q, ovr_q, tmo_q;

   state_e state_q, state_d;
   logic [CNT_W-1:0] issue_q, issue_d;
   logic             valid_q, valid_d;
   logic [6:0]       addr_q, addr_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [15:0]      count_q, count_d;
   logic             tmo_set, strm_en, commit;

   logic req, take, busy;
   logic [10:0] wrd, trig_off, sub_off;
   logic hit_trig, hit_sub, hit_thr, hit_ctrl, hit_count;
   logic [IDX_W-1:0] wb_idx;
   logic [THRESH_BITS-1:0] ram_wb_dat;
   logic wr_thr, drop_set, ctrl_wr, start_req, start, ovr_set;
   logic w1c_drop, w1c_ovr, w1c_tmo;
   logic [31:0] rd_word;
   logic beat_sub;
   logic [CNT_W-1:0] beat_beam;
   logic unused_inputs;

   assign unused_inputs = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

   // A request is taken once; served_q blocks re-ack until cyc&stb drops.
   assign req  = wb_cyc_i & wb_stb_i;
   assign take = req & ~ack_q & ~served_q;
   assign busy = (state_q != ST_IDLE);

   assign wrd       = word_of(wb_adr_i);
   assign trig_off  = wrd - WRD_TRIG;
   assign sub_off   = wrd - WRD_SUB;
   assign hit_trig  = (trig_off < NB_WRD);
   assign hit_sub   = (sub_off < NB_WRD);
   assign hit_thr   = hit_trig | hit_sub;
   assign hit_ctrl  = (wrd == WRD_CTRL);
   assign hit_count = (wrd == WRD_COUNT);
   assign wb_idx    = hit_sub ? (IDX_W'(sub_off) + IDX_W'(NBEAMS)) : IDX_W'(trig_off);

   assign wr_thr    = take & wb_we_i & hit_thr & ~busy;
   assign drop_set  = take & wb_we_i & hit_thr & busy;
   assign ctrl_wr   = take & wb_we_i & hit_ctrl;
   assign start_req = ctrl_wr & wb_dat_i[CTRL_START_BIT];
   assign start     = start_req & ~busy;
   assign ovr_set   = start_req & busy;
   assign w1c_drop  = ctrl_wr & wb_dat_i[CTRL_DROP_BIT];
   assign w1c_ovr   = ctrl_wr & wb_dat_i[CTRL_OVERRUN_BIT];
   assign w1c_tmo   = ctrl_wr & wb_dat_i[CTRL_TIMEOUT_BIT];

   l1_thresh_ram #(
      .DEPTH (DEPTH),
      .WIDTH (THRESH_BITS),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk_i      (wb_clk_i),
      .wb_we_i    (wr_thr),
      .wb_idx_i   (wb_idx),
      .wb_dat_i   (wb_dat_i[THRESH_BITS-1:0]),
      .wb_dat_o   (ram_wb_dat),
      .strm_en_i  (strm_en),
      .strm_idx_i (IDX_W'(issue_q)),
      .strm_dat_o (thr_dat_o)
   );

   always_comb begin
      rd_word = '0;
      if (hit_thr) begin
         rd_word = 32'(ram_wb_dat);
      end else if (hit_ctrl) begin
         rd_word[CTRL_START_BIT]   = busy;
         rd_word[CTRL_DROP_BIT]    = drop_q;
         rd_word[CTRL_OVERRUN_BIT] = ovr_q;
         rd_word[CTRL_TIMEOUT_BIT] = tmo_q;
      end else if (hit_count) begin
         rd_word = {16'b0, count_q};
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         served_q <= 1'b0;
         wb_dat_q <= '0;
         drop_q   <= 1'b0;
         ovr_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         ack_q    <= take;
         served_q <= req & (served_q | ack_q);
         wb_dat_q <= (take & ~wb_we_i) ? rd_word : '0;
         // Set events take priority over a same-cycle write-1-to-clear.
         drop_q   <= (drop_q & ~w1c_drop) | drop_set;
         ovr_q    <= (ovr_q  & ~w1c_ovr)  | ovr_set;
         tmo_q    <= (tmo_q  & ~w1c_tmo)  | tmo_set;
      end
   end

   assign beat_sub  = (issue_q >= NB_CNT);
   assign beat_beam = beat_sub ? (issue_q - NB_CNT) : issue_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         issue_q <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         to_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         issue_q <= issue_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         to_q    <= to_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      issue_d = issue_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      to_d    = to_q;
      count_d = count_q;
      tmo_set = 1'b0;
      strm_en = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            to_d = '0;
            if (start) begin
               state_d = ST_STREAM;
               issue_d = '0;
               valid_d = 1'b0;
            end
         end
         ST_STREAM: begin
            // The output register refills on the same edge that a beat is accepted.
            if (!valid_q || thr_ready_i) begin
               if (issue_q != BEATS) begin
                  strm_en = 1'b1;
                  issue_d = issue_q + 1'b1;
                  valid_d = 1'b1;
                  addr_d  = {beat_sub, 6'(beat_beam)};
               end else if (valid_q) begin
                  valid_d = 1'b0;
                  state_d = ST_COMMIT;
               end
            end
         end
         ST_COMMIT: begin
            commit  = 1'b1;
            to_d    = '0;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (thr_done_i) begin
               state_d = ST_IDLE;
               count_d = count_q + 16'd1;
               to_d    = '0;
            end else if (to_q == TO_LAST) begin
               state_d = ST_IDLE;
               tmo_set = 1'b1;
               to_d    = '0;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign wb_ack_o     = ack_q;
   assign wb_err_o     = 1'b0;
   assign wb_rty_o     = 1'b0;
   assign wb_dat_o     = wb_dat_q;
   assign thr_addr_o   = addr_q;
   assign thr_valid_o  = valid_q;
   assign thr_commit_o = commit;

endmodule

`default_nettype wire
